// File: rtl/ctu_tsr_sar_ctl.sv
`default_nettype none
// ============================================================================
// Module      : ctu_tsr_sar_ctl
// Description : Successive-approximation controller for the on-die
//               temperature sensor. Drives trial DAC codes to the sensor,
//               reads back the synchronised comparator, resolves a DAC_W-bit
//               temperature code and raises a sticky over-temp alarm.
// Revision    : 1.0 - initial release
// ============================================================================
module ctu_tsr_sar_ctl #(
   parameter int DAC_W      = 8,
   parameter int SETTLE_CYC = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             tsr_cmp,
   input  logic [DAC_W-1:0] thresh,
   input  logic             alarm_clr,
   output logic [DAC_W-1:0] tsr_dac_code,
   output logic             busy,
   output logic             done,
   output logic [DAC_W-1:0] result,
   output logic             over_temp
);

   localparam int CNT_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
   localparam int IDX_W = (DAC_W > 1) ? $clog2(DAC_W) : 1;

   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_MSB    = IDX_W'(DAC_W - 1);
   localparam logic [DAC_W-1:0] CODE_ONE   = DAC_W'(1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] bit_idx;
   logic             cmp_meta;
   logic             cmp_s;
   logic [DAC_W-1:0] trial_bit;
   logic [DAC_W-1:0] code_kept;
   logic             last_sample;
   logic             set_alarm;

   // Current trial bit, and the code once the comparator verdict is applied
   assign trial_bit   = CODE_ONE << bit_idx;
   assign code_kept   = cmp_s ? tsr_dac_code : (tsr_dac_code & ~trial_bit);
   assign last_sample = (state == S_SAMPLE) && (bit_idx == '0);
   assign set_alarm   = last_sample && (code_kept >= thresh);

   // Two-flop synchroniser for the asynchronous pad comparator
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmp_meta <= 1'b0;
         cmp_s    <= 1'b0;
      end else begin
         cmp_meta <= tsr_cmp;
         cmp_s    <= cmp_meta;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_SETTLE;
         S_SETTLE: if (cnt == '0) state_nxt = S_SAMPLE;
         S_SAMPLE: state_nxt = (bit_idx == '0) ? S_DONE : S_SETTLE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Status outputs decoded from the state
   always_comb begin
      busy = (state != S_IDLE);
      done = (state == S_DONE);
   end

   // Conversion datapath: settle counter, bit index, trial code and result.
   // The result is loaded on the edge into DONE so it is valid alongside done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt          <= '0;
         bit_idx      <= '0;
         tsr_dac_code <= '0;
         result       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  cnt          <= CNT_RELOAD;
                  bit_idx      <= IDX_MSB;
                  tsr_dac_code <= CODE_ONE << IDX_MSB;
               end
            end
            S_SETTLE: begin
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
            end
            S_SAMPLE: begin
               if (bit_idx != '0) begin
                  tsr_dac_code <= code_kept | (trial_bit >> 1);
                  bit_idx      <= bit_idx - IDX_W'(1);
                  cnt          <= CNT_RELOAD;
               end else begin
                  tsr_dac_code <= code_kept;
                  result       <= code_kept;
               end
            end
            default: ;
         endcase
      end
   end

   // Sticky over-temp alarm; a new alarm takes priority over a clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         over_temp <= 1'b0;
      end else if (set_alarm) begin
         over_temp <= 1'b1;
      end else if (alarm_clr) begin
         over_temp <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ctu_tsr_sar_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctu_tsr_sar_ctl
// Description : Directed self-checking bench for ctu_tsr_sar_ctl, covering the
//               default 8-bit instance and a small 4-bit / 3-cycle instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctu_tsr_sar_ctl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] level;
   logic [7:0] thresh;
   logic       alarm_clr;
   logic       tsr_cmp;
   logic [7:0] tsr_dac_code;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       over_temp;

   logic       start2;
   logic [3:0] level2;
   logic [3:0] thresh2;
   logic       alarm_clr2;
   logic       tsr_cmp2;
   logic [3:0] tsr_dac_code2;
   logic       busy2;
   logic       done2;
   logic [3:0] result2;
   logic       over_temp2;

   int errors = 0;
   int checks = 0;

   // Results captured by run_conv
   int         done_cyc;
   int         ndone;
   logic [7:0] res_done;
   logic       ot_done;
   logic       busy_after;
   logic [7:0] trials [8];

   // Sensor model: comparator reports sensor level >= trial code
   assign tsr_cmp  = (level >= tsr_dac_code);
   assign tsr_cmp2 = (level2 >= tsr_dac_code2);

   always #5 clk = ~clk;

   ctu_tsr_sar_ctl dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .tsr_cmp      (tsr_cmp),
      .thresh       (thresh),
      .alarm_clr    (alarm_clr),
      .tsr_dac_code (tsr_dac_code),
      .busy         (busy),
      .done         (done),
      .result       (result),
      .over_temp    (over_temp)
   );

   ctu_tsr_sar_ctl #(.DAC_W(4), .SETTLE_CYC(3)) dut_small (
      .clk          (clk),
      .rst          (rst),
      .start        (start2),
      .tsr_cmp      (tsr_cmp2),
      .thresh       (thresh2),
      .alarm_clr    (alarm_clr2),
      .tsr_dac_code (tsr_dac_code2),
      .busy         (busy2),
      .done         (done2),
      .result       (result2),
      .over_temp    (over_temp2)
   );

   // Issue a start in the current cycle (cycle 0) and follow the conversion
   // up to the cycle after the first done. Called at a negedge.
   task automatic run_conv(input logic [7:0] lvl, input bit extra_start, input int clr_cyc);
      level      = lvl;
      start      = 1'b1;
      done_cyc   = -1;
      ndone      = 0;
      busy_after = 1'b1;
      res_done   = 8'hxx;
      ot_done    = 1'bx;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc <= 300; cyc++) begin
         if (done === 1'b1) begin
            ndone++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               res_done = result;
               ot_done  = over_temp;
            end
         end
         if (((cyc - 1) % 17 == 0) && (cyc <= 120)) trials[(cyc - 1) / 17] = tsr_dac_code;
         if ((done_cyc >= 0) && (cyc == done_cyc + 1)) begin
            busy_after = busy;
            break;
         end
         start     = extra_start && ((cyc == 5) || (cyc == 60));
         alarm_clr = (cyc == clr_cyc);
         @(negedge clk);
      end
      start     = 1'b0;
      alarm_clr = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({busy, done, tsr_dac_code, result, over_temp} !== 19'd0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b code=%h result=%h ot=%b, required all 0",
                  busy, done, tsr_dac_code, result, over_temp);
      end
      level = 8'h33;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || tsr_dac_code !== 8'h80) begin
         errors++;
         $display("FAIL reset_pre_busy: busy=%b code=%h, required 1 80", busy, tsr_dac_code);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, tsr_dac_code, result, over_temp} !== 19'd0) begin
         errors++;
         $display("FAIL reset_mid_settle: busy=%b done=%b code=%h result=%h ot=%b, required all 0",
                  busy, done, tsr_dac_code, result, over_temp);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_conv(8'h33, 1'b0, -1);
      checks++;
      if (done_cyc !== 137 || res_done !== 8'h33) begin
         errors++;
         $display("FAIL reset_recover: done_cycle=%0d result=%h, required 137 33", done_cyc, res_done);
      end
   endtask

   task automatic test_main();
      logic [7:0] exp_trials [8];
      exp_trials = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};
      @(negedge clk);
      run_conv(8'h5A, 1'b0, -1);
      checks++;
      if (done_cyc !== 137 || res_done !== 8'h5A || ndone !== 1) begin
         errors++;
         $display("FAIL main_conv: done_cycle=%0d result=%h dones=%0d, required 137 5a 1",
                  done_cyc, res_done, ndone);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (trials[i] !== exp_trials[i]) begin
            errors++;
            $display("FAIL main_trial%0d: code=%h, required %h", i, trials[i], exp_trials[i]);
         end
      end
      checks++;
      if (busy_after !== 1'b0 || over_temp !== 1'b0) begin
         errors++;
         $display("FAIL main_after: busy=%b ot=%b, required 0 0", busy_after, over_temp);
      end
   endtask

   task automatic test_boundaries();
      logic [7:0] lvls [2];
      lvls = '{8'h00, 8'hFF};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         run_conv(lvls[i], 1'b0, -1);
         checks++;
         if (res_done !== lvls[i] || ndone !== 1 || busy_after !== 1'b0 || done_cyc !== 137) begin
            errors++;
            $display("FAIL boundary_%h: result=%h dones=%0d busy_after=%b done_cycle=%0d, required %h 1 0 137",
                     lvls[i], res_done, ndone, busy_after, done_cyc, lvls[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      run_conv(8'h21, 1'b1, -1);
      checks++;
      if (done_cyc !== 137 || ndone !== 1 || res_done !== 8'h21 || busy_after !== 1'b0) begin
         errors++;
         $display("FAIL ignored_start: done_cycle=%0d dones=%0d result=%h busy_after=%b, required 137 1 21 0",
                  done_cyc, ndone, res_done, busy_after);
      end
      // Now in cycle 138 of the previous conversion: start again immediately
      run_conv(8'hC7, 1'b0, -1);
      checks++;
      if (done_cyc !== 137 || res_done !== 8'hC7 || ndone !== 1) begin
         errors++;
         $display("FAIL back_to_back: done_cycle=%0d result=%h dones=%0d, required 137 c7 1",
                  done_cyc, res_done, ndone);
      end
   endtask

   task automatic test_over_temp();
      // Alarm may be set from the 0xFF boundary run; clear it first
      @(negedge clk);
      alarm_clr = 1'b1;
      @(negedge clk);
      alarm_clr = 1'b0;
      checks++;
      if (over_temp !== 1'b0) begin
         errors++;
         $display("FAIL ot_initial_clear: ot=%b, required 0", over_temp);
      end
      thresh = 8'h5A;
      run_conv(8'h59, 1'b0, -1);
      checks++;
      if (ot_done !== 1'b0 || res_done !== 8'h59) begin
         errors++;
         $display("FAIL ot_below: ot=%b result=%h, required 0 59", ot_done, res_done);
      end
      run_conv(8'h5A, 1'b0, -1);
      checks++;
      if (ot_done !== 1'b1) begin
         errors++;
         $display("FAIL ot_set: ot_at_done=%b, required 1", ot_done);
      end
      // Clear asserted in the cycle whose edge sets the alarm again
      run_conv(8'h5A, 1'b0, 136);
      checks++;
      if (ot_done !== 1'b1 || over_temp !== 1'b1) begin
         errors++;
         $display("FAIL ot_set_wins: ot_at_done=%b ot_after=%b, required 1 1", ot_done, over_temp);
      end
      alarm_clr = 1'b1;
      @(negedge clk);
      alarm_clr = 1'b0;
      checks++;
      if (over_temp !== 1'b0) begin
         errors++;
         $display("FAIL ot_clear: ot=%b, required 0", over_temp);
      end
   endtask

   task automatic test_small();
      int         dcyc;
      int         nd;
      logic [3:0] res;
      dcyc = -1;
      nd   = 0;
      res  = 4'hx;
      @(negedge clk);
      level2 = 4'h9;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         if (done2 === 1'b1) begin
            nd++;
            if (dcyc < 0) begin
               dcyc = cyc;
               res  = result2;
            end
         end
         @(negedge clk);
      end
      checks++;
      if (dcyc !== 17 || res !== 4'h9 || nd !== 1 || busy2 !== 1'b0) begin
         errors++;
         $display("FAIL small_conv: done_cycle=%0d result=%h dones=%0d busy=%b, required 17 9 1 0",
                  dcyc, res, nd, busy2);
      end
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      level      = 8'h00;
      thresh     = 8'hFF;
      alarm_clr  = 1'b0;
      start2     = 1'b0;
      level2     = 4'h0;
      thresh2    = 4'hF;
      alarm_clr2 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_main();
      test_boundaries();
      test_back_to_back();
      test_over_temp();
      test_small();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
